// File: rtl/button_pkg.sv
// Shared types and constants for the multi-channel button conditioner.
// Timing defaults assume a 50 MHz system clock.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } btn_state_e;

    // 10 ms debounce, 90 ms lockout, 500 ms first repeat, 100 ms repeat
    localparam int DEBOUNCE = 500000;
    localparam int LOCKOUT  = 4500000;
    localparam int REPEAT   = 25000000;
    localparam int REPEAT_P = 5000000;

    localparam int CH_COIN  = 0;
    localparam int CH_START = 1;
    localparam int CH_FIRE  = 2;
    localparam int CH_MOVE  = 3;

    function automatic int maxInt(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // True when an unsigned counter of the given width can reach value
    function automatic bit cntFits(int width, int value);
        longint unsigned lim;
        if (width >= 63) return 1'b1;
        lim = 64'd1 << width;
        return longint'(value) < longint'(lim);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce/lockout FSM.
// Optional auto-repeat press pulses when AUTO_REPEAT_EN is defined.
module button_channel
    import button_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 10,
`ifdef AUTO_REPEAT_EN
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
`endif
    parameter int CNT_W           = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic btnPin,
    output logic level,
    output logic pressPulse,
    output logic releasePulse,
    output logic busy
);

    localparam logic             RELEASED  = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_END    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LOCK_END  = CNT_W'(LOCKOUT_CYCLES);
    // cnt is compared before its increment lands, hence the minus one
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    logic             syncA;
    logic             syncB;
    logic             pressed;
    btn_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rcnt;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] rptCnt;
    logic             rptArmed;
    logic [CNT_W-1:0] rptTarget;

    assign rptTarget = rptArmed ? RPT_NEXT : RPT_FIRST;
`endif

    // Bring the raw pin into the clock domain, idling at the released level
    always_ff @(posedge clk) begin
        if (reset) begin
            syncA <= RELEASED;
            syncB <= RELEASED;
        end else begin
            syncA <= btnPin;
            syncB <= syncA;
        end
    end

    assign pressed = syncB ^ RELEASED;

    // Debounce, lockout and pulse generation for this channel
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rcnt         <= '0;
            level        <= 1'b0;
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
            busy         <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rptCnt       <= '0;
            rptArmed     <= 1'b0;
`endif
        end else begin
            pressPulse   <= 1'b0;
            releasePulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= PRESS_DB;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (!pressed) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == DB_END) begin
                        state      <= HELD;
                        cnt        <= '0;
                        pressPulse <= 1'b1;
                        level      <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        rptCnt     <= '0;
                        rptArmed   <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (cnt != LOCK_END) begin
                        cnt <= cnt + CNT_ONE;
                    end
                    if (!pressed && cnt >= LOCK_LAST) begin
                        state <= REL_DB;
                        rcnt  <= CNT_ONE;
                    end
`ifdef AUTO_REPEAT_EN
                    if (pressed) begin
                        if (rptCnt + CNT_ONE == rptTarget) begin
                            pressPulse <= 1'b1;
                            rptCnt     <= '0;
                            rptArmed   <= 1'b1;
                        end else begin
                            rptCnt <= rptCnt + CNT_ONE;
                        end
                    end
`endif
                end
                REL_DB: begin
                    if (pressed) begin
                        state <= HELD;
                        rcnt  <= '0;
`ifdef AUTO_REPEAT_EN
                        rptCnt <= '0;
`endif
                    end else if (rcnt == DB_END) begin
                        state        <= IDLE;
                        rcnt         <= '0;
                        cnt          <= '0;
                        level        <= 1'b0;
                        releasePulse <= 1'b1;
                        busy         <= 1'b0;
                    end else begin
                        rcnt <= rcnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_button_conditioner.sv
// N-channel push-button conditioner built from independent channels.
// Define AUTO_REPEAT_EN to enable held-button auto-repeat press pulses.
module multi_button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE,
    parameter int LOCKOUT_CYCLES  = LOCKOUT,
    parameter int CNT_W           = 32,
    parameter int REPEAT_DELAY    = REPEAT,
    parameter int REPEAT_PERIOD   = REPEAT_P
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] i_btn,
    output logic [NUM_CH-1:0] o_level,
    output logic [NUM_CH-1:0] o_press,
    output logic [NUM_CH-1:0] o_release,
    output logic              o_any_press,
    output logic              o_busy
);

`ifdef AUTO_REPEAT_EN
    localparam int CNT_NEED =
        maxInt(maxInt(DEBOUNCE_CYCLES, LOCKOUT_CYCLES), REPEAT_DELAY);
`else
    localparam int CNT_NEED = maxInt(DEBOUNCE_CYCLES, LOCKOUT_CYCLES);
`endif

    // A counter that could wrap would silently break every timing rule
    if (!cntFits(CNT_W, CNT_NEED)) begin : gCntWidthErr
        $error("CNT_W too small for the configured cycle counts");
    end

    if (DEBOUNCE_CYCLES < 1 || LOCKOUT_CYCLES < 1 ||
        REPEAT_PERIOD < 1 || REPEAT_DELAY < LOCKOUT_CYCLES) begin : gParamErr
        $error("illegal timing parameters");
    end

    logic [NUM_CH-1:0] chBusy;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gCh
        button_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LOCKOUT_CYCLES  (LOCKOUT_CYCLES),
`ifdef AUTO_REPEAT_EN
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
            .CNT_W           (CNT_W)
        ) uChannel (
            .clk          (clk),
            .reset        (reset),
            .btnPin       (i_btn[ch]),
            .level        (o_level[ch]),
            .pressPulse   (o_press[ch]),
            .releasePulse (o_release[ch]),
            .busy         (chBusy[ch])
        );
    end

    assign o_any_press = |o_press;
    assign o_busy      = |chBusy;

endmodule

// File: tb/tb_multi_button_conditioner.sv
// Directed bench for multi_button_conditioner (2 channels, active-low).
// Cycle n is the interval after the n-th clock edge of a scenario.
module tb_multi_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] i_btn;
    logic [1:0] o_level;
    logic [1:0] o_press;
    logic [1:0] o_release;
    logic       o_any_press;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    logic [1:0] expLevel;
    logic [1:0] expPress;
    logic [1:0] expRel;
    logic       expAny;
    logic       expBusy;

    multi_button_conditioner #(
        .NUM_CH          (2),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (4),
        .LOCKOUT_CYCLES  (10),
        .CNT_W           (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_btn       (i_btn),
        .o_level     (o_level),
        .o_press     (o_press),
        .o_release   (o_release),
        .o_any_press (o_any_press),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic idle_gap();
        i_btn = 2'b11;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_btn = 2'b11;
        reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            if (n == 3) reset = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if ({o_level, o_press, o_release} !== 6'b0) begin
                errors++;
                $display("FAIL reset cyc %0d lvl/prs/rel=%b required 000000",
                         n, {o_level, o_press, o_release});
            end
            checks++;
            if ({o_any_press, o_busy} !== 2'b00) begin
                errors++;
                $display("FAIL reset cyc %0d any/busy=%b required 00",
                         n, {o_any_press, o_busy});
            end
        end
    endtask

    task automatic test_glitch();
        for (int n = 0; n <= 10; n++) begin
            i_btn = {1'b1, !(n <= 2)};
            @(posedge clk);
            #1;
            expPress = 2'b00;
            expBusy  = (n >= 2 && n <= 4);
            checks++;
            if (o_press !== expPress || o_level !== 2'b00) begin
                errors++;
                $display("FAIL glitch cyc %0d press=%b level=%b required 00 00",
                         n, o_press, o_level);
            end
            checks++;
            if (o_busy !== expBusy) begin
                errors++;
                $display("FAIL glitch busy cyc %0d got %b required %b",
                         n, o_busy, expBusy);
            end
        end
    endtask

    task automatic test_clean_press();
        for (int n = 0; n <= 45; n++) begin
            i_btn = {1'b1, !(n < 30)};
            @(posedge clk);
            #1;
            expPress = {1'b0, n == 6};
            expLevel = {1'b0, n >= 6 && n <= 35};
            expRel   = {1'b0, n == 36};
            expAny   = (n == 6);
            expBusy  = (n >= 2 && n <= 35);
            checks++;
            if (o_press !== expPress || o_any_press !== expAny) begin
                errors++;
                $display("FAIL clean press cyc %0d press=%b any=%b required %b %b",
                         n, o_press, o_any_press, expPress, expAny);
            end
            checks++;
            if (o_level !== expLevel) begin
                errors++;
                $display("FAIL clean level cyc %0d got %b required %b",
                         n, o_level, expLevel);
            end
            checks++;
            if (o_release !== expRel || o_busy !== expBusy) begin
                errors++;
                $display("FAIL clean rel/busy cyc %0d got %b %b required %b %b",
                         n, o_release, o_busy, expRel, expBusy);
            end
        end
    endtask

    task automatic test_short_press();
        for (int n = 0; n <= 30; n++) begin
            i_btn = {1'b1, !(n <= 7)};
            @(posedge clk);
            #1;
            expPress = {1'b0, n == 6};
            expLevel = {1'b0, n >= 6 && n <= 19};
            expRel   = {1'b0, n == 20};
            expBusy  = (n >= 2 && n <= 19);
            checks++;
            if (o_press !== expPress) begin
                errors++;
                $display("FAIL short press cyc %0d got %b required %b",
                         n, o_press, expPress);
            end
            checks++;
            if (o_level !== expLevel) begin
                errors++;
                $display("FAIL short level cyc %0d got %b required %b",
                         n, o_level, expLevel);
            end
            checks++;
            if (o_release !== expRel || o_busy !== expBusy) begin
                errors++;
                $display("FAIL short rel/busy cyc %0d got %b %b required %b %b",
                         n, o_release, o_busy, expRel, expBusy);
            end
        end
    endtask

    task automatic test_bounce_held();
        for (int n = 0; n <= 55; n++) begin
            i_btn = {1'b1, (n == 20 || n == 21 || n >= 40)};
            @(posedge clk);
            #1;
            expPress = {1'b0, n == 6};
            expLevel = {1'b0, n >= 6 && n <= 45};
            expRel   = {1'b0, n == 46};
            expBusy  = (n >= 2 && n <= 45);
            checks++;
            if (o_press !== expPress) begin
                errors++;
                $display("FAIL bounce press cyc %0d got %b required %b",
                         n, o_press, expPress);
            end
            checks++;
            if (o_level !== expLevel) begin
                errors++;
                $display("FAIL bounce level cyc %0d got %b required %b",
                         n, o_level, expLevel);
            end
            checks++;
            if (o_release !== expRel || o_busy !== expBusy) begin
                errors++;
                $display("FAIL bounce rel/busy cyc %0d got %b %b required %b %b",
                         n, o_release, o_busy, expRel, expBusy);
            end
        end
    endtask

    task automatic test_simultaneous_reset();
        for (int n = 0; n <= 30; n++) begin
            i_btn = (n >= 11) ? 2'b11 : 2'b00;
            reset = (n == 11 || n == 12);
            @(posedge clk);
            #1;
            expPress = (n == 6) ? 2'b11 : 2'b00;
            expAny   = (n == 6);
            expLevel = (n >= 6 && n <= 10) ? 2'b11 : 2'b00;
            expBusy  = (n >= 2 && n <= 10);
            checks++;
            if (o_press !== expPress || o_any_press !== expAny) begin
                errors++;
                $display("FAIL simul press cyc %0d press=%b any=%b required %b %b",
                         n, o_press, o_any_press, expPress, expAny);
            end
            checks++;
            if (o_level !== expLevel) begin
                errors++;
                $display("FAIL simul level cyc %0d got %b required %b",
                         n, o_level, expLevel);
            end
            checks++;
            if (o_release !== 2'b00 || o_busy !== expBusy) begin
                errors++;
                $display("FAIL simul rel/busy cyc %0d got %b %b required 00 %b",
                         n, o_release, o_busy, expBusy);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        i_btn = 2'b11;
        test_reset();
        idle_gap();
        test_glitch();
        idle_gap();
        test_clean_press();
        idle_gap();
        test_short_press();
        idle_gap();
        test_bounce_held();
        idle_gap();
        test_simultaneous_reset();
        idle_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
